// File: rtl/timer_counter_pkg.sv
// timer_counter_pkg: shared definitions for the bus-attached down-counter/timer.
//   - FSM state encoding (IDLE/LOAD/CNT/INT)
//   - register word offsets (addr[3:2])
//   - CTRL bit positions and MODE codes
package timer_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_IM       = 3;
  localparam int unsigned CTRL_W        = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_counter_if.sv
// timer_counter_if: system-bus slot seen by the timer.
//   addr [1:0]  word address bits [3:2]      (master -> slave)
//   we          decoded write enable         (master -> slave)
//   wd   [31:0] write data                   (master -> slave)
//   rd   [31:0] combinational read data      (slave -> master)
//   irq         interrupt request to CP0     (slave -> master)
interface timer_counter_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  modport master (output addr, we, wd, input rd, irq);
  modport slave  (input addr, we, wd, output rd, irq);
endinterface

// File: rtl/timer_counter.sv
// timer_counter: programmable 32-bit down-counter/timer on bus slot 0.
//   clk    system clock, rising edge
//   reset  synchronous active-low reset
//   bus    timer_counter_if.slave: addr/we/wd in, rd (combinational)/irq out
// Registers: CTRL (0) {IM, MODE[1:0], EN}, PRESET (1), COUNT (2, read-only).
// irq = IM & pending; one-shot holds irq until a CTRL write, auto-reload
// pulses it for one cycle every PRESET+2 cycles.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
  input logic             clk,
  input logic             reset,
  timer_counter_if.slave  bus
);

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [31:0]         preset_q, preset_d;
  logic [31:0]         count_q, count_d;
  logic                pending_q, pending_d;

  logic                en;
  logic                reload;

  assign en     = ctrl_q[CTRL_EN];
  assign reload = (ctrl_q[CTRL_MODE_LSB +: 2] == MODE_RELOAD);

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        // COUNT<=1 terminates, so PRESET==0 behaves like PRESET==1
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d   = '0;
          pending_d = 1'b1;
          state_d   = ST_INT;
        end
      end
      ST_INT: begin
        if (reload) begin
          pending_d = 1'b0;
          state_d   = ST_LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = ST_IDLE;
        end
      end
    endcase

    // Bus writes are applied last so a CTRL write in the INT cycle
    // overrides the FSM clearing EN.
    if (bus.we) begin
      if (bus.addr == REG_CTRL) begin
        ctrl_d    = bus.wd[CTRL_W-1:0];
        pending_d = 1'b0;
      end else if (bus.addr == REG_PRESET) begin
        preset_d = bus.wd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      preset_q  <= PRESET_RST;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    bus.rd = '0;
    unique case (bus.addr)
      REG_CTRL:   bus.rd = {{(32-CTRL_W){1'b0}}, ctrl_q};
      REG_PRESET: bus.rd = preset_q;
      REG_COUNT:  bus.rd = count_q;
      default:    bus.rd = '0;
    endcase
  end

  assign bus.irq = ctrl_q[CTRL_IM] & pending_q;

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: self-checking bench for timer_counter.
module tb_timer_counter;
  import timer_counter_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  logic clk;
  logic reset;
  timer_counter_if bus ();

  timer_counter #(.PRESET_RST(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  sb_item_t    sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.wd   = d;
    bus.we   = 1'b1;
    tick();
    bus.we   = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rd;
  endtask

  task automatic do_reset();
    bus.we = 1'b0;
    reset  = 1'b0;
    tick();
    check("irq_in_reset", {31'b0, bus.irq}, 32'd0);
    tick();
    reset = 1'b1;
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_check(input logic [31:0] got);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      it = sb_q.pop_front();
      check(it.tag, got, it.exp);
    end
  endtask

  logic [31:0] v;

  initial begin
    reset   = 1'b0;
    bus.addr = '0;
    bus.we   = 1'b0;
    bus.wd   = '0;
    tick();
    tick();
    reset = 1'b1;

    // ---- one-shot, PRESET=5 ----
    bus_write(REG_PRESET, 32'd5);
    bus_write(REG_CTRL, 32'h9);          // edge 0
    for (int i = 0; i < 6; i++) sb_push("os_count", 32'(5 - i));
    tick();                              // edge 1
    tick();                              // edge 2
    for (int i = 0; i < 6; i++) begin
      bus_read(REG_COUNT, v);
      sb_check(v);
      if (i == 4) check("os_irq_before", {31'b0, bus.irq}, 32'd0);
      if (i == 5) check("os_irq_edge7", {31'b0, bus.irq}, 32'd1);
      tick();
    end
    bus_read(REG_CTRL, v);
    check("os_ctrl_en_cleared", v, 32'h8);
    tick();
    tick();
    check("os_irq_held", {31'b0, bus.irq}, 32'd1);
    bus_write(REG_CTRL, 32'h0);
    check("os_irq_dropped", {31'b0, bus.irq}, 32'd0);

    // ---- auto-reload, PRESET=3: pulses after edges 5,10,15,20 ----
    bus_write(REG_PRESET, 32'd3);
    bus_write(REG_CTRL, 32'hB);          // edge 0
    for (int k = 1; k <= 21; k++)
      sb_push("ar_irq", (k >= 5 && ((k - 5) % 5) == 0) ? 32'd1 : 32'd0);
    for (int k = 1; k <= 21; k++) begin
      tick();
      sb_check({31'b0, bus.irq});
    end
    bus_write(REG_CTRL, 32'h0);

    // ---- masked one-shot, PRESET=2 ----
    do_reset();
    bus_write(REG_PRESET, 32'd2);
    bus_write(REG_CTRL, 32'h1);          // edge 0, INT at edge 4
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (bus.irq !== 1'b0) check("mask_irq", {31'b0, bus.irq}, 32'd0);
    end
    check("mask_irq_final", {31'b0, bus.irq}, 32'd0);
    bus_read(REG_COUNT, v);
    check("mask_count_zero", v, 32'd0);
    bus_read(REG_CTRL, v);
    check("mask_ctrl_zero", v, 32'd0);

    // ---- pause at COUNT=7 then re-enable ----
    do_reset();
    bus_write(REG_PRESET, 32'd10);
    bus_write(REG_CTRL, 32'h1);          // edge 0
    tick(); tick(); tick(); tick();      // edge 4: COUNT=8
    bus_read(REG_COUNT, v);
    check("pause_count8", v, 32'd8);
    bus_write(REG_CTRL, 32'h0);          // edge 5: COUNT=7, EN=0
    bus_read(REG_COUNT, v);
    check("pause_count7", v, 32'd7);
    tick();
    check("pause_state_idle", {30'b0, dut.state_q}, {30'b0, ST_IDLE});
    tick(); tick();
    bus_read(REG_COUNT, v);
    check("pause_frozen", v, 32'd7);
    bus_write(REG_CTRL, 32'h1);
    tick();
    tick();
    bus_read(REG_COUNT, v);
    check("pause_reload", v, 32'd10);
    bus_write(REG_CTRL, 32'h0);

    // ---- ignored writes ----
    do_reset();
    bus_write(REG_COUNT, 32'h1234);
    bus_read(REG_COUNT, v);
    check("count_write_ignored", v, 32'd0);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, v);
    check("addr3_reads_zero", v, 32'd0);
    bus_write(REG_CTRL, 32'hFFFF_FFF0);
    bus_read(REG_CTRL, v);
    check("ctrl_upper_ignored", v, 32'd0);

    // ---- PRESET=0, then CTRL write in the INT cycle ----
    bus_write(REG_PRESET, 32'd0);
    bus_write(REG_CTRL, 32'h9);          // edge 0
    tick();
    tick();
    check("p0_irq_edge2", {31'b0, bus.irq}, 32'd0);
    tick();
    check("p0_irq_edge3", {31'b0, bus.irq}, 32'd1);
    bus_write(REG_CTRL, 32'h9);          // captured in the INT cycle
    bus_read(REG_CTRL, v);
    check("int_write_en_kept", v, 32'h9);
    check("int_write_pending_clr", {31'b0, bus.irq}, 32'd0);

    // ---- reset during CNT ----
    bus_write(REG_CTRL, 32'h0);
    bus_write(REG_PRESET, 32'd20);
    bus_write(REG_CTRL, 32'h9);
    tick(); tick(); tick(); tick();
    do_reset();
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), v);
      check("rst_rd", v, 32'd0);
    end
    check("rst_irq", {31'b0, bus.irq}, 32'd0);
    check("rst_state", {30'b0, dut.state_q}, {30'b0, ST_IDLE});
    for (int k = 0; k < 25; k++) begin
      tick();
      if (bus.irq !== 1'b0) check("rst_no_irq", {31'b0, bus.irq}, 32'd0);
    end
    bus_read(REG_COUNT, v);
    check("rst_count_idle", v, 32'd0);

    if (sb_q.size() != 0) check("sb_leftover", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Bus-attached programmable down-counter/timer: device slot 0 on the processor system bus, downstream of the address-decoding bridge.
- Receives word address, write data and its decoded write enable; returns read data combinationally.
- Raises a maskable interrupt request to the CP0 hardware-interrupt input.
- Three word registers: CTRL (offset 0x0), PRESET (0x4), COUNT (0x8, read-only).

Parameters:
- PRESET_RST, 32'h0000_0000, reset value of PRESET

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- addr  input  2  word address bits [3:2] from the bridge
- we  input  1  write enable (bridge DEVWE for this slot)
- wd  input  32  write data
- rd  output  32  read data, combinational
- irq  output  1  interrupt request, registered-state derived

Behaviour:
- Reset: sampled on rising edge while reset==0.
  - CTRL=0, PRESET=PRESET_RST, COUNT=0, pending=0, state=IDLE.
  - irq=0 from the first cycle after the reset edge.
  - Reset mid-count aborts immediately; no irq pulse is produced.
- CTRL fields (all other bits write-ignored, read 0):
  - bit0 EN: count enable.
  - bits[2:1] MODE: 00 one-shot, 01 auto-reload; 10/11 behave as 00.
  - bit3 IM: interrupt mask (1 = enabled).
- Reads: rd = CTRL (addr 0), PRESET (1), COUNT (2), 32'h0 (3). Purely combinational, zero latency. Reads have no side effects.
- Writes take effect at the clock edge where we==1:
  - addr 0 writes CTRL; any CTRL write also clears pending.
  - addr 1 writes PRESET. A running count is unaffected; the new value is used at the next LOAD.
  - addr 2 and addr 3 writes are ignored.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: EN==1 -> LOAD; otherwise stay. COUNT holds.
  - LOAD: COUNT<=PRESET; -> CNT.
  - CNT:
    - EN==0 -> IDLE (COUNT frozen).
    - else COUNT>1 -> COUNT<=COUNT-1.
    - else COUNT<=0, pending<=1 -> INT.
  - INT, one-shot: CTRL.EN<=0, pending stays 1; -> IDLE.
  - INT, auto-reload: pending<=0; -> LOAD. The irq pulse lasts exactly one cycle.
- irq = IM & pending.
  - One-shot: irq is held until software writes CTRL.
  - Auto-reload: irq is a 1-cycle pulse every PRESET+2 cycles.
- Latency: let the CTRL write with EN=1 be captured at edge 0.
  - LOAD is entered at edge 1; CNT with COUNT=PRESET at edge 2.
  - INT is entered and pending set at edge max(PRESET,1)+2.
  - PRESET==0 behaves as PRESET==1.
- Simultaneous events:
  - A bus CTRL write in the INT cycle wins over the FSM clearing EN; pending is still cleared by that write.
  - A CTRL write clearing EN during CNT leaves state CNT for IDLE on the following edge.
  - Arithmetic is 32-bit unsigned; COUNT never wraps below 0.

Decomposition:
- Shared package holds:
  - state encodings (IDLE/LOAD/CNT/INT, 2-bit);
  - register word offsets (CTRL=0, PRESET=1, COUNT=2);
  - CTRL bit positions and MODE codes (MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01).
- Single flat module; no sub-module is natural at this size.

Test Plan:
- Reset: drive reset=0 for 2 edges with prior register contents nonzero -> rd=0 for all addr, irq=0, state IDLE.
- One-shot: write PRESET=5, then CTRL=0x9 -> COUNT reads 5,4,3,2,1,0 on successive cycles starting 2 edges after the write. irq=1 after edge 7, held; CTRL reads 0x8 (EN cleared). Writing CTRL=0 drops irq next cycle.
- Auto-reload: PRESET=3, CTRL=0xB -> irq pulses high exactly one cycle, every 5 cycles, for at least 4 periods.
- Mask/pause:
  - CTRL=0x1 (IM=0), PRESET=2 -> counter reaches 0, irq stays 0, and CTRL still reads 0x0 after the count completes.
  - Separately, clear EN mid-count at COUNT=7 -> COUNT frozen at 7 and state returns to IDLE. Re-enable -> reloads PRESET.
- Writes and boundaries:
  - Write COUNT=0x1234 -> ignored.
  - PRESET=0 with CTRL=0x9 -> irq after edge 3.
  - CTRL write in the INT cycle with wd=0x9 -> EN remains 1 and pending is cleared.
  - Assert reset during CNT -> no irq, all registers 0.
